// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter in front of one shared slave.
// Round-robin grant taken in IDLE, held for the granted master's whole cycle,
// with a wait-state watchdog that aborts a stalled transfer with an error.
module wb_arbiter_2m #(
  parameter logic [7:0] TIMEOUT = 8'd255  // stall limit in cycles, 0 disables
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // master 0
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // shared slave
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  // debug
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t      state, state_nxt;
  logic [1:0]  gnt, gnt_nxt;     // one-hot grant
  logic        last, last_nxt;   // master served most recently
  logic [7:0]  wcnt, wcnt_nxt;   // consecutive stalled strobe cycles

  logic [1:0]  cyc;
  logic        gsel, busy, abort, g_cyc;
  logic [1:0]  m_ack, m_err;
  logic [1:0][31:0] m_dat;

  assign cyc   = {m1_cyc_i, m0_cyc_i};
  assign gsel  = gnt[1];
  assign busy  = (state == BUSY);
  assign abort = (state == ABORT);
  assign g_cyc = gsel ? m1_cyc_i : m0_cyc_i;

  // Slave side: forward the granted master only while BUSY, zero otherwise.
  assign s_cyc_o = busy & g_cyc;
  assign s_stb_o = busy & (gsel ? m1_stb_i : m0_stb_i);
  assign s_we_o  = busy & (gsel ? m1_we_i : m0_we_i);
  assign s_sel_o = busy ? (gsel ? m1_sel_i : m0_sel_i) : '0;
  assign s_adr_o = busy ? (gsel ? m1_adr_i : m0_adr_i) : '0;
  assign s_dat_o = busy ? (gsel ? m1_dat_i : m0_dat_i) : '0;

  // Master side: slave response passes straight through to the granted
  // master; the watchdog error comes from the registered ABORT state.
  for (genvar i = 0; i < 2; i++) begin : g_rsp
    assign m_ack[i] = busy & gnt[i] & s_ack_i;
    assign m_err[i] = gnt[i] & ((busy & s_err_i) | abort);
    assign m_dat[i] = (busy & gnt[i]) ? s_dat_i : '0;
  end

  assign m0_ack_o = m_ack[0];
  assign m0_err_o = m_err[0];
  assign m0_dat_o = m_dat[0];
  assign m1_ack_o = m_ack[1];
  assign m1_err_o = m_err[1];
  assign m1_dat_o = m_dat[1];
  assign gnt_o    = gnt;

  // Next-state, grant, round-robin pointer and watchdog counter.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    wcnt_nxt  = '0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (|cyc) begin
          state_nxt = BUSY;
          if (&cyc) gnt_nxt = last ? 2'b01 : 2'b10;
          else      gnt_nxt = cyc;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          // cycle ended; an ack/err in this same cycle was already passed on
          state_nxt = IDLE;
          gnt_nxt   = '0;
          last_nxt  = gsel;
        end else if (TIMEOUT != 8'd0 && wcnt == TIMEOUT && !s_ack_i && !s_err_i) begin
          state_nxt = ABORT;
        end else if (s_stb_o && !s_ack_i && !s_err_i) begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      ABORT: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        last_nxt  = gsel;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // State registers; reset takes effect immediately, even mid-transfer.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= 1'b1;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the bus-timeout limit in wb_clk_i cycles (8-bit, 0 = timeout disabled).
REQ-002 SHALL have port wb_clk_i, input, 1, the single clock for all logic.
REQ-003 SHALL have port wb_rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have ports mN_cyc_i, mN_stb_i, mN_we_i (N=0,1), input, 1 each, Wishbone master N cycle/strobe/write.
REQ-005 SHALL have port mN_sel_i, input, 4, master N byte select.
REQ-006 SHALL have ports mN_adr_i and mN_dat_i, input, 32 each, master N address and write data.
REQ-007 SHALL have port mN_dat_o, output, 32, read data to master N.
REQ-008 SHALL have ports mN_ack_o and mN_err_o, output, 1 each, acknowledge and error to master N.
REQ-009 SHALL have ports s_cyc_o, s_stb_o, s_we_o, output, 1 each, to the shared slave (e.g. sw_reg bank).
REQ-010 SHALL have port s_sel_o, output, 4, and ports s_adr_o and s_dat_o, output, 32 each, to the shared slave.
REQ-011 SHALL have port s_dat_i, input, 32, and ports s_ack_i and s_err_i, input, 1 each, from the shared slave.
REQ-012 SHALL have port gnt_o, output, 2, one-hot current grant (bit N = master N), for debug.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, BUSY and ABORT.
REQ-014 IDLE: if any mN_cyc_i is high, SHALL register the grant and enter BUSY next cycle (one-cycle arbitration latency).
REQ-015 Both cyc high in IDLE: SHALL grant the master not served last (round-robin); the "last" pointer SHALL reset to master 1, so master 0 wins the first contest.
REQ-016 BUSY: s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o SHALL combinationally follow the granted master's inputs.
REQ-017 BUSY: granted mN_ack_o/mN_err_o/mN_dat_o SHALL follow s_ack_i/s_err_i/s_dat_i combinationally (zero added latency).
REQ-018 The non-granted master SHALL see ack=0, err=0, dat_o=0 at all times.
REQ-019 In IDLE and ABORT, s_cyc_o and s_stb_o SHALL be 0; s_we_o, s_sel_o, s_adr_o and s_dat_o SHALL be 0.
REQ-020 Grant SHALL be held for the whole of the granted master's cyc, including multiple strobes.
REQ-021 When the granted master's cyc falls, SHALL return to IDLE next cycle and update "last" to that master.
REQ-022 Ack or err in the same cycle that cyc falls SHALL still be delivered to the granted master.
REQ-023 BUSY: an 8-bit wait counter SHALL increment each cycle with s_stb_o=1 and s_ack_i=s_err_i=0.
REQ-024 The wait counter SHALL clear on ack, on err, on s_stb_o=0, and on entering BUSY.
REQ-025 With TIMEOUT≠0, when the counter equals TIMEOUT, SHALL enter ABORT next cycle.
REQ-026 ABORT SHALL last one cycle and assert the granted master's err_o registered for that cycle only, then return to IDLE with "last" set to that master.
REQ-027 A master still holding cyc after ABORT SHALL re-arbitrate normally.
REQ-028 With TIMEOUT=0, the counter SHALL never trigger ABORT.
REQ-029 A request arriving while BUSY SHALL wait, with no ack/err, until IDLE.
REQ-030 gnt_o SHALL be non-zero only in BUSY and ABORT.

Reset
REQ-031 Asserting wb_rst_i SHALL force IDLE, gnt_o=0, counter=0 and last=master 1 immediately, even mid-transfer.
REQ-032 During and after reset, all master and slave outputs SHALL be 0 until a new grant.
REQ-033 No request SHALL be granted while wb_rst_i is high.

Verification
REQ-034 m0 write adr 0x0, dat 0xEEEEEEEE, slave acks 1 cycle after stb -> s_* mirror m0; m0_ack_o=1 one cycle; m1 outputs stay 0.
REQ-035 m0 and m1 assert cyc in the same cycle after reset -> m0 granted (gnt_o=01); after m0 drops cyc, IDLE one cycle, then gnt_o=10.
REQ-036 m1 cyc held, m0 requests during m1 BUSY -> m0 gets no ack until m1 drops cyc; m0 is granted next arbitration.
REQ-037 TIMEOUT=4, slave never acks -> s_stb_o high 5 cycles, ABORT, granted m*_err_o=1 one cycle, s_cyc_o=0, IDLE.
REQ-038 wb_rst_i pulsed mid-read -> s_cyc_o=0 and gnt_o=0 without waiting for a clock edge; a fresh m1-only request after reset is granted after one cycle.
REQ-039 Slave s_err_i=1 on a read -> granted err_o=1 same cycle, no ABORT, counter cleared.
